// File: rtl/uart_rx_multi.sv
// uart_rx_multi: oversampling UART receiver with runtime character format
// (5..MAX_DATA_W data bits, optional odd/even parity, one or two stop bits),
// valid/ready output handshake, overrun and break reporting.
// Optional feature: define UART_RX_MAJORITY_VOTE_EN to decide each bit by a
// 2-of-3 vote around mid-bit instead of a single mid-bit sample.
module uart_rx_multi #(
  parameter int MAX_DATA_W   = 9,
  parameter int OVERSAMPLE   = 16,
  parameter int SAMPLE_CNT_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  baud_en_i,
  input  logic                  rx_en_i,
  input  logic                  uart_rx_i,
  input  logic [5:0]            rx_conf_i,
  output logic [MAX_DATA_W-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  rx_busy_o,
  output logic                  rx_parity_err_o,
  output logic                  rx_frame_err_o,
  output logic                  rx_overrun_o,
  output logic                  rx_break_o
);

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  localparam int IDX_W = $clog2(MAX_DATA_W);
  localparam logic [SAMPLE_CNT_W-1:0] CNT_LAST = SAMPLE_CNT_W'(OVERSAMPLE - 1);

  // Latched configuration fields: {data_code[2:0], stop2, parity_odd, parity_en}
  logic [5:0]              conf_reg;
  logic [2:0]              state_reg;
  logic [SAMPLE_CNT_W-1:0] cnt_reg;
  logic [SAMPLE_CNT_W-1:0] cnt_next;
  logic [IDX_W-1:0]        bit_idx_reg;
  logic                    stop_idx_reg;
  logic [MAX_DATA_W-1:0]   shift_reg;
  logic                    bit_reg;
  logic                    par_bit_reg;
  logic                    any_one_reg;
  logic                    frame_acc_reg;
  logic                    brk_wait_reg;

  logic [MAX_DATA_W-1:0]   data_out_reg;
  logic                    valid_reg;
  logic                    perr_reg;
  logic                    ferr_reg;
  logic                    ovr_reg;
  logic                    brk_reg;

  logic                    bit_val;
  logic                    at_sample;
  logic                    at_end;
  logic [3:0]              code_bits;
  logic [3:0]              nbits;
  logic [IDX_W-1:0]        last_bit;
  logic [MAX_DATA_W-1:0]   bit_sel;
  logic                    frame_end;
  logic                    complete;
  logic                    is_break;
  logic                    parity_err;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [SAMPLE_CNT_W-1:0] CNT_SAMPLE = SAMPLE_CNT_W'(OVERSAMPLE/2);
  localparam logic [SAMPLE_CNT_W-1:0] CNT_VOTE_A = SAMPLE_CNT_W'(OVERSAMPLE/2 - 2);
  localparam logic [SAMPLE_CNT_W-1:0] CNT_VOTE_B = SAMPLE_CNT_W'(OVERSAMPLE/2 - 1);

  logic vote_a_reg;
  logic vote_b_reg;

  // Capture the two early votes; the third is the live line at the decision tick
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vote_a_reg <= 1'b0;
      vote_b_reg <= 1'b0;
    end else if (baud_en_i) begin
      if (cnt_reg == CNT_VOTE_A) vote_a_reg <= uart_rx_i;
      if (cnt_reg == CNT_VOTE_B) vote_b_reg <= uart_rx_i;
    end
  end

  assign bit_val = (vote_a_reg & vote_b_reg) | (vote_a_reg & uart_rx_i) |
                   (vote_b_reg & uart_rx_i);
`else
  localparam logic [SAMPLE_CNT_W-1:0] CNT_SAMPLE = SAMPLE_CNT_W'(OVERSAMPLE/2 - 1);

  assign bit_val = uart_rx_i;
`endif

  assign at_sample = (cnt_reg == CNT_SAMPLE);
  assign at_end    = (cnt_reg == CNT_LAST);
  assign cnt_next  = at_end ? '0 : cnt_reg + 1'b1;

  // Character length from the latched code, clamped to the data port width
  always_comb begin
    code_bits = 4'd5 + {1'b0, conf_reg[5:3]};
    nbits     = (code_bits > 4'(MAX_DATA_W)) ? 4'(MAX_DATA_W) : code_bits;
    last_bit  = IDX_W'(nbits - 4'd1);
  end

  // One-hot write enable for the data bit currently being received
  for (genvar gi = 0; gi < MAX_DATA_W; gi++) begin : g_bit_sel
    assign bit_sel[gi] = (bit_idx_reg == IDX_W'(gi));
  end

  // A frame ends on the tick that closes the last stop bit
  assign frame_end  = baud_en_i && rx_en_i && (state_reg == ST_STOP) && !brk_wait_reg &&
                      at_end && (stop_idx_reg == conf_reg[2]);
  assign complete   = frame_end && any_one_reg;
  assign is_break   = frame_end && !any_one_reg;
  assign parity_err = conf_reg[0] && ((^shift_reg ^ par_bit_reg) != conf_reg[1]);

  // Receive FSM: all progress is gated by the oversample tick
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg     <= ST_OFF;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      stop_idx_reg  <= 1'b0;
      conf_reg      <= '0;
      shift_reg     <= '0;
      bit_reg       <= 1'b0;
      par_bit_reg   <= 1'b0;
      any_one_reg   <= 1'b0;
      frame_acc_reg <= 1'b0;
      brk_wait_reg  <= 1'b0;
    end else if (baud_en_i) begin
      if (!rx_en_i) begin
        state_reg    <= ST_OFF;
        cnt_reg      <= '0;
        brk_wait_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_OFF: state_reg <= ST_IDLE;
          ST_IDLE: begin
            conf_reg <= rx_conf_i;
            cnt_reg  <= '0;
            if (!uart_rx_i) state_reg <= ST_START;
          end
          ST_START: begin
            cnt_reg <= cnt_next;
            if (at_sample) bit_reg <= bit_val;
            if (at_end) begin
              if (bit_reg) begin
                state_reg <= ST_IDLE;
              end else begin
                state_reg     <= ST_DATA;
                bit_idx_reg   <= '0;
                shift_reg     <= '0;
                par_bit_reg   <= 1'b0;
                any_one_reg   <= 1'b0;
                frame_acc_reg <= 1'b0;
              end
            end
          end
          ST_DATA: begin
            cnt_reg <= cnt_next;
            if (at_sample) begin
              shift_reg   <= (shift_reg & ~bit_sel) | (bit_sel & {MAX_DATA_W{bit_val}});
              any_one_reg <= any_one_reg | bit_val;
            end
            if (at_end) begin
              if (bit_idx_reg == last_bit) begin
                state_reg    <= conf_reg[0] ? ST_PARITY : ST_STOP;
                stop_idx_reg <= 1'b0;
              end else begin
                bit_idx_reg <= bit_idx_reg + 1'b1;
              end
            end
          end
          ST_PARITY: begin
            cnt_reg <= cnt_next;
            if (at_sample) begin
              par_bit_reg <= bit_val;
              any_one_reg <= any_one_reg | bit_val;
            end
            if (at_end) begin
              state_reg    <= ST_STOP;
              stop_idx_reg <= 1'b0;
            end
          end
          ST_STOP: begin
            if (brk_wait_reg) begin
              // Break seen: stay here until the line returns high
              if (uart_rx_i) begin
                state_reg    <= ST_IDLE;
                brk_wait_reg <= 1'b0;
              end
            end else begin
              cnt_reg <= cnt_next;
              if (at_sample) begin
                if (!bit_val) frame_acc_reg <= 1'b1;
                any_one_reg <= any_one_reg | bit_val;
              end
              if (at_end) begin
                if (stop_idx_reg == conf_reg[2]) begin
                  if (any_one_reg) state_reg <= ST_IDLE;
                  else             brk_wait_reg <= 1'b1;
                end else begin
                  stop_idx_reg <= 1'b1;
                end
              end
            end
          end
          default: state_reg <= ST_OFF;
        endcase
      end
    end
  end

  // Output holding register with valid/ready handshake, overrun and break pulses
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      ovr_reg      <= 1'b0;
      brk_reg      <= 1'b0;
    end else begin
      ovr_reg <= 1'b0;
      brk_reg <= is_break;
      if (valid_reg && rx_ready_i) valid_reg <= 1'b0;
      if (complete) begin
        if (!valid_reg || rx_ready_i) begin
          data_out_reg <= shift_reg;
          perr_reg     <= parity_err;
          ferr_reg     <= frame_acc_reg;
          valid_reg    <= 1'b1;
        end else begin
          ovr_reg <= 1'b1;
        end
      end
    end
  end

  assign rx_data_o       = data_out_reg;
  assign rx_valid_o      = valid_reg;
  assign rx_parity_err_o = perr_reg;
  assign rx_frame_err_o  = ferr_reg;
  assign rx_overrun_o    = ovr_reg;
  assign rx_break_o      = brk_reg;
  assign rx_busy_o       = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                           (state_reg == ST_PARITY) || (state_reg == ST_STOP);

endmodule

// File: doc/uart_rx_multi.md
UART_RX_MULTI -- requirements
Module: uart_rx_multi

Interface
REQ-001 SHALL have parameter MAX_DATA_W, default 9, maximum data bits per character (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud_en_i ticks per bit (legal 8..32, even).
REQ-003 SHALL have parameter SAMPLE_CNT_W, default 5, sample counter width (>= clog2(OVERSAMPLE)).
REQ-004 SHALL have ports: clk_i  in  1  single clock; rst_ni  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: baud_en_i  in  1  oversample tick; rx_en_i  in  1  receiver enable; uart_rx_i  in  1  synchronised serial input.
REQ-006 SHALL have port rx_conf_i  in  6  {data_code[2:0], stop2, parity_odd, parity_en}; data bits = min(5+data_code, MAX_DATA_W).
REQ-007 SHALL have ports: rx_data_o  out  MAX_DATA_W  received character, LSB first, unused MSBs zero; rx_valid_o  out  1; rx_ready_i  in  1.
REQ-008 SHALL have status outputs (1 bit each): rx_busy_o, rx_parity_err_o, rx_frame_err_o, rx_overrun_o, rx_break_o.

Function
REQ-009 SHALL implement FSM states Off, Idle, Start, Data, Parity, Stop; state, counters and sampling advance only on cycles with baud_en_i=1.
REQ-010 SHALL go Off->Idle when rx_en_i=1, and from any state to Off when rx_en_i=0 at a tick, discarding any partial frame.
REQ-011 SHALL latch rx_conf_i on every tick spent in Idle; config changes during a frame SHALL not affect that frame.
REQ-012 SHALL go Idle->Start on a tick with uart_rx_i=0; sample counter cleared to 0 on entry.
REQ-013 SHALL sample each bit at counter value OVERSAMPLE/2-1; in Start a sampled 1 SHALL return to Idle at counter OVERSAMPLE-1 (glitch rejection).
REQ-014 SHALL leave every bit period at counter OVERSAMPLE-1, counter wrapping to 0.
REQ-015 SHALL store data bit k into rx_data_o bit k; Data->Parity if parity_en, else Data->Stop, after the last data bit.
REQ-016 SHALL compute parity error = (XOR of data bits XOR parity bit) != parity_odd.
REQ-017 SHALL check one stop bit, or two if stop2; any sampled 0 stop bit SHALL set frame error for that character.
REQ-018 SHALL, at the end of the last stop bit, go to Idle and complete the character in the same clk_i cycle.
REQ-019 SHALL, on completion with rx_valid_o=0, update rx_data_o, rx_parity_err_o, rx_frame_err_o and assert rx_valid_o next cycle.
REQ-020 SHALL hold rx_valid_o and data/error outputs stable until a cycle with rx_valid_o=1 and rx_ready_i=1, after which rx_valid_o=0.
REQ-021 SHALL, on completion while rx_valid_o=1 and rx_ready_i=0, drop the new character, keep old data, pulse rx_overrun_o high for one clk_i cycle.
REQ-022 SHALL treat completion in the same cycle as a handshake as no overrun; new character loads and rx_valid_o stays 1.
REQ-023 SHALL, when all data, parity (if enabled) and stop samples are 0, pulse rx_break_o one cycle instead of presenting a character, then hold in Stop until uart_rx_i=1 is sampled, then Idle.
REQ-024 SHALL drive rx_busy_o=1 in Start, Data, Parity, Stop, else 0.

Reset
REQ-025 SHALL, with rst_ni=0 at a clk_i edge, enter Off, clear counters and latched config, drive all outputs 0 regardless of baud_en_i.
REQ-026 SHALL, on reset mid-frame or with rx_valid_o=1, discard the frame and pending character.

Configuration
REQ-027 SHALL, with macro UART_RX_MAJORITY_VOTE_EN defined, determine each bit by 2-of-3 majority of samples at counter OVERSAMPLE/2-2, OVERSAMPLE/2-1, OVERSAMPLE/2.
REQ-028 SHALL, without UART_RX_MAJORITY_VOTE_EN, use the single sample at OVERSAMPLE/2-1; all other behaviour identical.

Verification
REQ-029 SHALL test 8N1 0xA5, ready=1 -> rx_data_o=0x0A5, rx_valid_o 1 cycle, no errors.
REQ-030 SHALL test 9 bits, even parity, 0x1FF, wrong parity bit 0 -> data 0x1FF, rx_parity_err_o=1.
REQ-031 SHALL test two 8N1 characters 0x11, 0x22, ready=0 -> data 0x11 held, rx_overrun_o one-cycle pulse.
REQ-032 SHALL test a uart_rx_i low pulse of 3 ticks in Idle -> return to Idle, rx_valid_o stays 0.
REQ-033 SHALL test line held low for 12 bit times, 8N1 -> rx_break_o pulse, no rx_valid_o, Idle after line high.
REQ-034 SHALL test rst_ni=0 mid Data, then 0x3C frame -> only 0x3C delivered.
